// File: rtl/rs232_ser_mf_pkg.sv
// Shared RS-232 definitions: parity modes, FSM state encodings, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs232_ser_mf_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Encodings are shared with the receiver, so S_PARITY exists even in builds without parity.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rs232_ser_mf_fifo.sv
// Single-clock FIFO, power-of-2 depth, head word visible combinationally on out_dat.
// Latency: a word written at edge N is readable from edge N.
// Backpressure: pushes while full and pops while empty are dropped.
module rs232_ser_mf_fifo
    import rs232_ser_mf_pkg::*;
#(
    parameter  int P_WIDTH = 8,
    parameter  int P_DEPTH = 4,
    localparam int AW      = clogb2(P_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic [P_WIDTH-1:0] in_dat,
    input  logic               out_rdy,
    output logic [P_WIDTH-1:0] out_dat,
    output logic [AW:0]        level,
    output logic               full,
    output logic               empty
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    assign full    = (level == (AW+1)'(P_DEPTH));
    assign empty   = (level == '0);
    assign push    = in_vld && !full;
    assign pop     = out_rdy && !empty;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rs232_ser_mf.sv
// Multi-format RS-232 transmitter with input FIFO; parity logic only with RS232_SER_MF_PARITY_EN.
// Latency: word accepted at edge N -> popped at N+1, start bit on tx from N+2; each bit exactly DIV cycles.
// Backpressure: tx_req is not acked while the FIFO is full; at most one accept per two cycles.
module rs232_ser_mf
    import rs232_ser_mf_pkg::*;
#(
    parameter  int P_CLK_FREQ_HZ = 100000000,
    parameter  int P_BAUD_RATE   = 9600,
    parameter  int P_DATA_BITS   = 8,
    parameter  int P_PARITY      = 0,
    parameter  int P_STOP_BITS   = 1,
    parameter  int P_FIFO_DEPTH  = 4,
    localparam int LW            = clogb2(P_FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tx,
    input  logic [7:0]    tx_data,
    input  logic          tx_req,
    output logic          tx_ack,
    output logic          tx_busy,
    output logic [LW-1:0] fifo_level
);

    localparam int         DIV   = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int         CW    = clogb2(DIV);
    localparam logic [7:0] DMASK = 8'((1 << P_DATA_BITS) - 1);

    if (DIV < 2) begin : g_bad_div
        $error("rs232_ser_mf: clock/baud ratio must be at least 2");
    end
    if (P_DATA_BITS < 5 || P_DATA_BITS > 8) begin : g_bad_dbits
        $error("rs232_ser_mf: data bits must be 5..8");
    end
    if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_sbits
        $error("rs232_ser_mf: stop bits must be 1 or 2");
    end
    if (P_PARITY != PAR_NONE && P_PARITY != PAR_EVEN && P_PARITY != PAR_ODD) begin : g_bad_par
        $error("rs232_ser_mf: unknown parity mode");
    end
    if ((P_FIFO_DEPTH < 2) || ((P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rs232_ser_mf: FIFO depth must be a power of two >= 2");
    end

`ifdef RS232_SER_MF_PARITY_EN
    localparam bit PAR_ACT = (P_PARITY != PAR_NONE);
    localparam bit PAR_INV = (P_PARITY == PAR_ODD);
    logic          par_bit;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          bit_end;
    logic          last_stop;
    logic          pop;

    // The ack cycle blocks a second accept of the same still-asserted request.
    assign accept    = tx_req && !tx_ack && !fifo_full;
    assign bit_end   = (cnt == CW'(DIV - 1));
    assign last_stop = (state == S_STOP) && bit_end && (bit_idx == 3'(P_STOP_BITS - 1));
    assign pop       = !fifo_empty && ((state == S_IDLE) || last_stop);

    rs232_ser_mf_fifo #(
        .P_WIDTH (8),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (accept),
        .in_dat  (tx_data),
        .out_rdy (pop),
        .out_dat (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // tx follows the current state one cycle late, so every bit keeps its full DIV cycles on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_ack  <= 1'b0;
            tx_busy <= 1'b0;
`ifdef RS232_SER_MF_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            tx_ack <= accept;

            if (state == S_IDLE || bit_end) cnt <= '0;
            else                            cnt <= cnt + CW'(1);

            if (pop) begin
                shreg   <= head & DMASK;
                state   <= S_START;
                bit_idx <= '0;
                tx_busy <= 1'b1;
`ifdef RS232_SER_MF_PARITY_EN
                par_bit <= (^(head & DMASK)) ^ PAR_INV;
`endif
            end

            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                end
                S_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    tx <= shreg[0];
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'(P_DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef RS232_SER_MF_PARITY_EN
                            state   <= PAR_ACT ? S_PARITY : S_STOP;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef RS232_SER_MF_PARITY_EN
                S_PARITY: begin
                    tx <= par_bit;
                    if (bit_end) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (last_stop) begin
                            if (fifo_empty) begin
                                state   <= S_IDLE;
                                tx_busy <= 1'b0;
                                bit_idx <= '0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
